lane_fifo9: RTL
===============

# lane_fifo9

Per-lane elastic buffer placed directly downstream of each output of the 1:2 byte demux in the physical-layer transmit path. It accepts 9-bit words (8 data bits plus a valid flag in bit 0), stores only the words flagged valid, and releases them to the lane logic on a pop request. Status flags give backpressure, and sticky error bits record overflow and underflow. Two instances are used, one per demux output.

## Interface
Parameters:
- DATA_W, 9, word width; bit 0 is the valid flag.
- DEPTH, 8, number of entries; must be a power of 2, at least 4.
- AFULL_TH, 6, almost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH.

Ports:
- clk, input, 1, single clock; all state changes on its rising edge.
- reset, input, 1, asynchronous, active-low; clears all state immediately when low.
- data_in, input, DATA_W, word from the demux; data_in[0]=1 requests a push.
- pop, input, 1, read request from the lane logic.
- data_out, output, DATA_W, registered head word; 0 when no successful pop occurred in the previous cycle.
- full, output, 1, count == DEPTH.
- empty, output, 1, count == 0.
- almost_full, output, 1, count >= AFULL_TH.
- almost_empty, output, 1, count <= AEMPTY_TH.
- count, output, log2(DEPTH)+1, number of stored words.
- overflow, output, 1, sticky; set when a push is dropped.
- underflow, output, 1, sticky; set when a pop hits an empty buffer.

## Operation
- Storage: circular buffer of DEPTH words with wr_ptr and rd_ptr, each log2(DEPTH) bits and wrapping naturally from DEPTH-1 to 0. The count register is the sole source of the flags.
- Push: when data_in[0]==1 and the push is accepted, the full 9-bit word is written at wr_ptr and wr_ptr increments. A word with data_in[0]==0 is never stored.
- A push is accepted when count < DEPTH, or when count == DEPTH and a pop succeeds in the same cycle.
- Pop: a pop succeeds when pop==1 and count > 0. On success, data_out <= mem[rd_ptr] and rd_ptr increments. In every other cycle, data_out <= 0.
- Count update: +1 for an accepted push without a successful pop. -1 for a successful pop without an accepted push. Unchanged when both or neither occur.
- Push and pop on a full buffer in the same cycle: both proceed, count stays DEPTH, and overflow is not set.
- Push and pop on an empty buffer in the same cycle: there is no bypass. The push is stored, the pop fails, data_out = 0, underflow is set, and count becomes 1.
- Overflow: a push request with count == DEPTH and no successful pop is dropped, and overflow is set to 1.
- Underflow: pop==1 with count == 0 sets underflow to 1.
- The sticky bits clear only on reset.
- Flags (full, empty, almost_full, almost_empty) are combinational decodes of the count register, with no dependence on the current inputs.

## Timing
- Reset (reset==0, asynchronous) forces the following immediately and holds them while low: data_out=0, count=0, wr_ptr=rd_ptr=0, overflow=0, underflow=0, empty=1, almost_empty=1, full=0, almost_full=0.
- Memory contents are not cleared by reset.
- Reset asserted mid-operation discards all stored words. The first push after deassertion is written to entry 0.
- After a rising edge with an accepted push, count and the flags reflect the new word in the same cycle.
- Write-to-read latency: a word pushed at edge N can be popped at edge N+1 and appears on data_out after edge N+1. Minimum latency from data_in to data_out is 2 edges.
- Pop-to-data latency: 1 cycle; data_out is valid for exactly one cycle per successful pop.
- Sustained throughput: 1 word per cycle with simultaneous push and pop.

## Test plan
- Reset, then push 0x0A3, 0x155, 0x1FF on 3 consecutive cycles with no pop. Drive data_in=0x0A2 (valid=0) for one cycle. Expected: count=3, almost_empty=0, empty=0.
- From that state, pop for 4 cycles. Expected: data_out = 0x0A3, 0x155, 0x1FF, 0x000; underflow=1 after the 4th pop; count=0.
- Push 8 words 0x001, 0x003, …, 0x00F. Expected: full=1 and almost_full=1 at count≥6. Then push 0x011 with no pop: word dropped, overflow=1, count stays 8. Then 8 pops return 0x001…0x00F in order.
- Fill to 8, then push 0x101 and pop in the same cycle. Expected: data_out=0x001, count=8, overflow=0. Pop 8 more: 0x003…0x00F followed by 0x101, exercising pointer wrap-around.
- With the buffer empty, push 0x0F1 and pop simultaneously. Expected: data_out=0, underflow=1, count=1. A pop on the next cycle returns 0x0F1.
- With 5 words stored, pulse reset low between clock edges. Expected: all outputs reach reset values before the next edge. After release, push 0x077 and pop on the next cycle: data_out=0x077.

Source files
------------

// File: rtl/lane_fifo9.sv
// rtl/lane_fifo9.sv - per-lane elastic buffer behind the 1:2 byte demux
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - asynchronous, active-low; clears pointers, count, flags, data_out
//   data_in      - DATA_W word; data_in[0]=1 requests a push of the whole word
//   pop          - read request from the lane logic
//   data_out     - registered head word, 0 in any cycle after a non-successful pop
//   full/empty   - count == DEPTH / count == 0
//   almost_full  - count >= AFULL_TH
//   almost_empty - count <= AEMPTY_TH
//   count        - number of stored words
//   overflow     - sticky, a push was dropped
//   underflow    - sticky, a pop hit an empty buffer
module lane_fifo9 #(
  parameter int DATA_W    = 9,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       pop,
  output logic [DATA_W-1:0]          data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic push_req;
  logic pop_ok;
  logic push_ok;
  logic is_empty;
  logic is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);
  assign push_req = data_in[0];
  assign pop_ok   = pop && !is_empty;
  // A full buffer still takes a push when the same cycle frees a slot.
  // There is no empty-buffer bypass: the pop fails and the push is stored.
  assign push_ok  = push_req && (!is_full || pop_ok);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = '0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem[rd_ptr_q];
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (push_req && !push_ok) begin
      overflow_d = 1'b1;
    end
    if (pop && is_empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign data_out     = data_out_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign full         = is_full;
  assign empty        = is_empty;
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);

endmodule
